// File: rtl/legv8_mc_control.sv
// legv8_mc_control: multicycle LEGv8 main control FSM with memory-ready stalls and retired-instruction counter
module legv8_mc_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             ior_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg2loc,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        CBZ_EXEC  = 4'd8,
        B_EXEC    = 4'd9,
        HALT      = 4'd15
    } state_t;
    state_t cur, nxt;
    logic   retire;
    logic   unused_zero;
    logic   is_r, is_ldur, is_stur, is_cbz, is_b;
    // zero is consumed by the datapath, which gates pc_write_cond itself
    assign unused_zero = zero;
    assign is_r    = opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
                     opcode == 11'b10001010000 || opcode == 11'b10101010000;
    assign is_ldur = opcode == 11'b11111000010;
    assign is_stur = opcode == 11'b11111000000;
    assign is_cbz  = opcode[10:3] == 8'b10110100;
    assign is_b    = opcode[10:5] == 6'b000101;
    assign state   = cur;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= FETCH;
            retired <= '0;
        end else begin
            cur     <= nxt;
            retired <= retired + {{(CNT_W-1){1'b0}}, retire};
        end
    end
    always_comb begin
        nxt           = cur;
        retire        = 1'b0;
        alu_op        = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg2loc       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        illegal_op    = 1'b0;
        case (cur)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                nxt       = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                reg2loc   = is_stur | is_cbz;
                nxt       = is_r ? R_EXEC : (is_ldur | is_stur) ? MEM_ADDR :
                            is_cbz ? CBZ_EXEC : is_b ? B_EXEC : HALT;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                reg2loc   = is_stur;
                nxt       = is_stur ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                nxt      = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                nxt        = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
                reg2loc   = 1'b1;
                retire    = mem_ready;
                nxt       = mem_ready ? FETCH : MEM_WRITE;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                nxt       = FETCH;
            end
            CBZ_EXEC: begin
                alu_src_a     = 1'b1;
                reg2loc       = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
                nxt           = FETCH;
            end
            B_EXEC: begin
                pc_write  = 1'b1;
                pc_source = 2'b01;
                retire    = 1'b1;
                nxt       = FETCH;
            end
            HALT: illegal_op = 1'b1;
            default: nxt = HALT;
        endcase
    end
endmodule

// File: tb/tb_legv8_mc_control.sv
// tb_legv8_mc_control: directed plus randomized instruction streams checked against a phase-level control model
module tb_legv8_mc_control;
    localparam int S_FETCH = 0, S_DECODE = 1, S_MADDR = 2, S_MREAD = 3, S_MWB = 4, S_MWRITE = 5;
    localparam int S_REXEC = 6, S_RWB = 7, S_CBZ = 8, S_B = 9, S_HALT = 15;
    localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;
    localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_n_w = 1'b0;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [1:0]  alu_op, pc_source, alu_src_b;
    logic        pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
    logic        reg2loc, alu_src_a, mem_to_reg, reg_write, illegal_op;
    logic [15:0] retired;
    logic [3:0]  state;
    logic [1:0]  w_alu_op, w_pc_source, w_alu_src_b;
    logic        w_pc_write, w_pc_write_cond, w_ior_d, w_mem_read, w_mem_write, w_ir_write;
    logic        w_reg2loc, w_alu_src_a, w_mem_to_reg, w_reg_write, w_illegal_op;
    logic [2:0]  w_retired;
    logic [3:0]  w_state;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] model_ret = '0;
    wire  [16:0] obs = {alu_op, pc_write, pc_write_cond, pc_source, ior_d, mem_read, mem_write,
                        ir_write, reg2loc, alu_src_a, alu_src_b, mem_to_reg, reg_write, illegal_op};

    always #5 clk = ~clk;

    legv8_mc_control #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg2loc(reg2loc), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal_op(illegal_op), .retired(retired), .state(state)
    );

    // narrow counter instance running unconditional branches back to back to exercise wraparound
    legv8_mc_control #(.CNT_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n_w), .opcode(11'b00010100000), .zero(1'b0), .mem_ready(1'b1),
        .alu_op(w_alu_op), .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .pc_source(w_pc_source),
        .ior_d(w_ior_d), .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
        .reg2loc(w_reg2loc), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .mem_to_reg(w_mem_to_reg),
        .reg_write(w_reg_write), .illegal_op(w_illegal_op), .retired(w_retired), .state(w_state)
    );

    function automatic int cls(logic [10:0] op);
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return C_R;
        if (op == OP_LDUR) return C_LD;
        if (op == OP_STUR) return C_ST;
        if (op[10:3] == 8'b10110100) return C_CBZ;
        if (op[10:5] == 6'b000101) return C_B;
        return C_ILL;
    endfunction

    // what each phase of an instruction must present on the control outputs
    function automatic logic [16:0] exp_vec(int st, int c, logic mr);
        logic [1:0] ao = 2'b00, ps = 2'b00, sb = 2'b00;
        logic pw = 0, pwc = 0, io = 0, mrd = 0, mw = 0, iw = 0, r2 = 0, sa = 0, m2r = 0, rw = 0, il = 0;
        case (st)
            S_FETCH:  begin mrd = 1; sb = 2'b01; iw = mr; pw = mr; end
            S_DECODE: begin sb = 2'b11; r2 = (c == C_ST || c == C_CBZ); end
            S_MADDR:  begin sa = 1; sb = 2'b10; r2 = (c == C_ST); end
            S_MREAD:  begin mrd = 1; io = 1; end
            S_MWB:    begin rw = 1; m2r = 1; end
            S_MWRITE: begin mw = 1; io = 1; r2 = 1; end
            S_REXEC:  begin sa = 1; ao = 2'b10; end
            S_RWB:    rw = 1;
            S_CBZ:    begin sa = 1; r2 = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            S_B:      begin pw = 1; ps = 2'b01; end
            S_HALT:   il = 1;
            default:  ;
        endcase
        return {ao, pw, pwc, ps, io, mrd, mw, iw, r2, sa, sb, m2r, rw, il};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // called just after a falling edge; leaves just after the next falling edge
    task automatic step(int st, int c, logic mr, string tag);
        mem_ready = mr;
        #1;
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".outs"}, 32'(obs), 32'(exp_vec(st, c, mr)));
        chk({tag, ".retired"}, 32'(retired), 32'(model_ret));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset(string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_state"}, 32'(state), 32'(S_FETCH));
        chk({tag, ".rst_outs"}, 32'(obs), 32'(exp_vec(S_FETCH, C_R, mem_ready)));
        chk({tag, ".rst_ret"}, 32'(retired), 32'h0);
        model_ret = '0;
        #1 rst_n = 1'b1;
    endtask

    task automatic run_instr(logic [10:0] op, int fw, int mw, string tag);
        int c = cls(op);
        opcode = op;
        for (int i = 0; i < fw; i++) step(S_FETCH, c, 1'b0, tag);
        step(S_FETCH, c, 1'b1, tag);
        step(S_DECODE, c, 1'($urandom), tag);
        case (c)
            C_R: begin
                step(S_REXEC, c, 1'($urandom), tag);
                step(S_RWB, c, 1'($urandom), tag);
            end
            C_LD: begin
                step(S_MADDR, c, 1'($urandom), tag);
                for (int i = 0; i < mw; i++) step(S_MREAD, c, 1'b0, tag);
                step(S_MREAD, c, 1'b1, tag);
                step(S_MWB, c, 1'($urandom), tag);
            end
            C_ST: begin
                step(S_MADDR, c, 1'($urandom), tag);
                for (int i = 0; i < mw; i++) step(S_MWRITE, c, 1'b0, tag);
                step(S_MWRITE, c, 1'b1, tag);
            end
            C_CBZ: step(S_CBZ, c, 1'($urandom), tag);
            C_B:   step(S_B, c, 1'($urandom), tag);
            default: begin
                for (int i = 0; i < 20; i++) step(S_HALT, c, 1'($urandom), tag);
                pulse_reset(tag);
            end
        endcase
        if (c != C_ILL) model_ret++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] op;
        @(negedge clk);
        rst_n_w = 1'b1;
        chk("wrap.reset", 32'(w_retired), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            repeat (3) @(posedge clk);
            #1 chk($sformatf("wrap.k%0d", k), 32'(w_retired), 32'(k % 8));
        end
        @(negedge clk);
        chk("reset.state", 32'(state), 32'(S_FETCH));
        chk("reset.retired", 32'(retired), 32'h0);
        rst_n = 1'b1;
        run_instr(OP_ADD, 0, 0, "add");
        run_instr(OP_LDUR, 0, 3, "ldur");
        run_instr(OP_STUR, 1, 2, "stur");
        run_instr(11'b10110100101, 0, 0, "cbz");
        run_instr(11'b00010100000, 0, 0, "b");
        run_instr(11'b11111111111, 0, 0, "halt");
        opcode = OP_ADD;
        step(S_FETCH, C_R, 1'b1, "abort");
        step(S_DECODE, C_R, 1'b0, "abort");
        mem_ready = 1'b1;
        #1 chk("abort.in_rexec", 32'(state), 32'(S_REXEC));
        pulse_reset("abort");
        rst_n = 1'b0;
        @(posedge clk);
        #1 chk("abort.held", 32'(state), 32'(S_FETCH));
        chk("abort.no_write", 32'(reg_write), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_AND;
                3: op = OP_ORR;
                4: op = OP_LDUR;
                5: op = OP_STUR;
                6: op = {8'b10110100, 3'($urandom)};
                7: op = {6'b000101, 5'($urandom)};
                8: op = (n % 2 == 0) ? OP_LDUR : OP_STUR;
                default: op = 11'($urandom);
            endcase
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
